// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined WIDTH-bit add/subtract with valid/ready handshake.
//
// The carry chain is cut into SEGS segments of SegW = ceil(WIDTH/SEGS) bits, and the
// last segment takes whatever remains. Each segment is resolved in its own register
// stage. Stage k adds segment k using the carry registered by stage k-1. It forwards
// the operands and the partial sum unchanged to the next stage.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands valid
//   in_ready   block accepts operands this cycle
//   add        1 = opa + opb, 0 = opa - opb
//   opa, opb   WIDTH-bit operands
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result modulo 2^WIDTH
//   co         add: carry out; sub: borrow (opa < opb unsigned)
//   ovf        two's-complement signed overflow
//   zero       sum == 0
module add_sub_pipe #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned SEGS  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             add,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SegW  = (SEGS == 0) ? WIDTH : (WIDTH + SEGS - 1) / SEGS;
    localparam int          LastW = int'(WIDTH) - (int'(SEGS) - 1) * int'(SegW);

    if (WIDTH < 2 || SEGS < 1 || SEGS > WIDTH || LastW < 1) begin : g_param_check
        $error("add_sub_pipe: unsupported WIDTH/SEGS combination");
    end

    // Index 0 holds the pipeline inputs. Index k+1 holds the registers of stage k.
    logic [WIDTH-1:0] a_st   [SEGS+1];
    logic [WIDTH-1:0] b_st   [SEGS+1];
    logic [WIDTH-1:0] s_st   [SEGS+1];
    logic             c_st   [SEGS+1];
    logic             sub_st [SEGS+1];
    logic             v_st   [SEGS+1];

    logic advance;
    logic co_q;
    logic ovf_q;
    logic zero_q;

    // A single global enable stalls every stage together. No per-stage skid is needed.
    assign advance  = ~v_st[SEGS] | out_ready;
    assign in_ready = ~rst_n | advance;

    // Subtraction is opa + ~opb + 1. The +1 enters as the carry into segment 0.
    assign a_st[0]   = opa;
    assign b_st[0]   = add ? opb : ~opb;
    assign s_st[0]   = '0;
    assign c_st[0]   = ~add;
    assign sub_st[0] = ~add;
    assign v_st[0]   = in_valid & in_ready;

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        localparam int unsigned Lo     = k * SegW;
        localparam int unsigned SegLen = (k == SEGS - 1) ? LastW : SegW;

        logic [SegLen:0]  seg_sum;
        logic [WIDTH-1:0] s_d;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             sub_q;
        logic             v_q;

        assign seg_sum = {1'b0, a_st[k][Lo +: SegLen]}
                       + {1'b0, b_st[k][Lo +: SegLen]}
                       + {{SegLen{1'b0}}, c_st[k]};

        always_comb begin
            s_d                = s_st[k];
            s_d[Lo +: SegLen]  = seg_sum[SegLen-1:0];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
                c_q   <= 1'b0;
                sub_q <= 1'b0;
                v_q   <= 1'b0;
            end else if (advance) begin
                a_q   <= a_st[k];
                b_q   <= b_st[k];
                s_q   <= s_d;
                c_q   <= seg_sum[SegLen];
                sub_q <= sub_st[k];
                v_q   <= v_st[k];
            end
        end

        assign a_st[k+1]   = a_q;
        assign b_st[k+1]   = b_q;
        assign s_st[k+1]   = s_q;
        assign c_st[k+1]   = c_q;
        assign sub_st[k+1] = sub_q;
        assign v_st[k+1]   = v_q;

        // The final stage also resolves the flags, so every output is a plain register.
        if (k == SEGS - 1) begin : g_flags
            logic ovf_d;
            logic zero_d;

            // b_st already holds ~opb for subtraction, so one rule covers both operations.
            assign ovf_d  = (a_st[k][WIDTH-1] == b_st[k][WIDTH-1]) &&
                            (s_d[WIDTH-1] != a_st[k][WIDTH-1]);
            assign zero_d = (s_d == '0);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    co_q   <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    // Invert the raw carry for subtraction so that it reads as a borrow.
                    co_q   <= seg_sum[SegLen] ^ sub_st[k];
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end

    logic unused_tail;
    assign unused_tail = ^{a_st[SEGS], b_st[SEGS], c_st[SEGS], sub_st[SEGS]};

    assign out_valid = v_st[SEGS];
    assign sum       = s_st[SEGS];
    assign co        = co_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
module tb_add_sub_pipe;

    localparam int unsigned W = 27;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         add;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    logic         zero;

    int checks   = 0;
    int failures = 0;
    int got;

    logic [W+2:0] exp_q[$];

    typedef struct {
        logic         op_add;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e_sum;
        logic         e_co;
        logic         e_ovf;
        logic         e_zero;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    add_sub_pipe #(
        .WIDTH(W),
        .SEGS (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .add      (add),
        .opa      (opa),
        .opb      (opb),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .co       (co),
        .ovf      (ovf),
        .zero     (zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result as {co, sum, ovf, zero}. It uses a 28-bit add/sub and signed-overflow rules.
    function automatic logic [W+2:0] model(input logic op_add, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0] r;
        logic       o;
        r = op_add ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
        if (op_add) o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        else        o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return {r, o, (r[W-1:0] == '0)};
    endfunction

    // Issue one op to an idle pipe, then wait for its result and compare.
    task automatic run_one(input string tag, input logic op_add, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] e_sum,
                           input logic e_co, input logic e_ovf, input logic e_zero);
        int lat;
        lat      = 0;
        add      = op_add;
        opa      = a;
        opb      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({tag, " latency"}, lat, 3);
        check({tag, " sum"}, sum, e_sum);
        check({tag, " co"}, co, e_co);
        check({tag, " ovf"}, ovf, e_ovf);
        check({tag, " zero"}, zero, e_zero);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        vecs[0]  = '{1'b1, 27'h7FFFFFF, 27'h0000001, 27'h0000000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 27'h00001FF, 27'h0000001, 27'h0000200, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 27'h003FFFF, 27'h0000001, 27'h0040000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 27'h3FFFFFF, 27'h0000001, 27'h4000000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 27'h0000005, 27'h0000007, 27'h7FFFFFE, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 27'h0000007, 27'h0000005, 27'h0000002, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 27'h0000000, 27'h0000000, 27'h0000000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 27'h4000000, 27'h0000001, 27'h3FFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 27'h4000000, 27'h4000000, 27'h0000000, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 27'h1234567, 27'h1234567, 27'h0000000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 27'h0000200, 27'h0000001, 27'h00001FF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 27'h3FFFFFF, 27'h3FFFFFF, 27'h7FFFFFE, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        add       = 1'b1;
        opa       = '0;
        opb       = '0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset outputs", {co, sum, ovf, zero}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].op_add, vecs[i].a, vecs[i].b,
                    vecs[i].e_sum, vecs[i].e_co, vecs[i].e_ovf, vecs[i].e_zero);
        end

        // Backpressure: 6 back-to-back ops, and out_ready is held low for 4 cycles
        got = 0;
        fork
            begin : drv
                for (int i = 0; i < 6; i++) begin
                    logic [W-1:0] ra;
                    logic [W-1:0] rb;
                    logic         rop;
                    bit           acc;
                    int           guard;
                    ra       = W'($urandom);
                    rb       = W'($urandom);
                    rop      = 1'($urandom);
                    add      = rop;
                    opa      = ra;
                    opb      = rb;
                    in_valid = 1'b1;
                    acc      = 1'b0;
                    guard    = 0;
                    while (!acc && guard < 50) begin
                        @(negedge clk);
                        #2;
                        acc = in_ready;
                        @(posedge clk);
                        #1;
                        guard++;
                    end
                    check("bp accept", acc, 1);
                    if (acc) exp_q.push_back(model(rop, ra, rb));
                end
                in_valid = 1'b0;
            end
            begin : mon
                bit           held;
                int           cyc;
                logic [W+2:0] snap;
                logic [W+2:0] e;
                held = 1'b0;
                cyc  = 0;
                while (got < 6 && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid && !held) begin
                        snap      = {co, sum, ovf, zero};
                        held      = 1'b1;
                        out_ready = 1'b0;
                        for (int h = 0; h < 4; h++) begin
                            @(negedge clk);
                            check("hold in_ready", in_ready, 0);
                            check("hold out_valid", out_valid, 1);
                            check("hold outputs", {co, sum, ovf, zero}, snap);
                        end
                        out_ready = 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        check("bp result expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check($sformatf("bp result%0d", got), {co, sum, ovf, zero}, e);
                        end
                        got++;
                    end
                end
            end
        join
        check("bp result count", got, 6);
        check("bp queue drained", exp_q.size(), 0);
        seen = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("bp no duplicate", seen, 0);
        @(posedge clk);
        #1;

        // Reset mid-flight: two ops in the pipe, and reset lands on the edge before the first result
        add      = 1'b1;
        opa      = 27'h0000123;
        opb      = 27'h0000456;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        add = 1'b0;
        opa = 27'h0000999;
        opb = 27'h0000111;
        @(posedge clk);
        #1;
        // This transfer is offered during reset and must be discarded.
        add   = 1'b1;
        opa   = 27'h0000001;
        opb   = 27'h0000001;
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("midreset out_valid", out_valid, 0);
        check("midreset outputs", {co, sum, ovf, zero}, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midreset nothing emitted", seen, 0);
        @(posedge clk);
        #1;
        run_one("post-reset", 1'b1, 27'h00ABCDE, 27'h0012345, 27'h00BE023, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
- Parametrised, pipelined successor to the FPU's 27-bit combinational mantissa add/sub.
- Splits the carry chain into SEGS equal-order segments, one register stage per segment, so wide mantissas close timing at full clock rate.
- Valid/ready handshake with backpressure on both sides.
- Adds signed-overflow and zero flags for the normalisation and rounding stages downstream.

Parameters:
WIDTH, 27, operand/sum width in bits (>= 2)
SEGS, 3, pipeline stages / carry-chain segments (1..WIDTH); segment k covers bits [k*SW +: SW] with SW = ceil(WIDTH/SEGS); last segment takes the remainder

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input operands valid
in_ready  out  1  block accepts input this cycle
add  in  1  1 = opa+opb, 0 = opa-opb
opa  in  WIDTH  operand A (unsigned magnitude; signed view used only for ovf)
opb  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result, modulo 2^WIDTH
co  out  1  add: carry out; sub: borrow (1 when opa < opb unsigned)
ovf  out  1  two's-complement signed overflow of the operation
zero  out  1  sum == 0

Behaviour:
- Reset is synchronous, active-low, sampled at the clk edge. It clears every stage valid bit; out_valid=0, sum=0, co=0, ovf=0, zero=0.
- in_ready is 1 during reset (rst_n=0). Transfers offered in a reset cycle are discarded.
- Reset mid-operation: all in-flight results are dropped and no partial result is ever emitted.
- Subtraction is computed as opa + ~opb + 1 (carry-in 1).
  - co = carry for add and ~carry for sub, so {co,sum} matches the legacy 28-bit add/sub result exactly.
- ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' = opb for add and ~opb for sub.
- zero = (sum == 0), evaluated on the full final sum.
- Pipeline structure:
  - Stage k registers segment k of the sum and the carry out of segment k.
  - Stage k also carries forward the unprocessed upper operand bits (opb already inverted for sub) and a valid bit.
  - Stage 0 uses carry-in = ~add.
- Global stall model: advance = ~out_valid | out_ready; in_ready = advance.
  - When advance=1, every stage shifts one position.
  - The stage-0 valid loads in_valid & in_ready, so bubbles propagate.
  - When advance=0, all stages hold.
- Latency is exactly SEGS cycles from the accepting edge to out_valid=1 when there is no backpressure. Throughput is 1 result per cycle.
- Outputs sum/co/ovf/zero are registered (final stage) and held stable while out_valid=1 && out_ready=0.
- Values on sum/co/ovf/zero when out_valid=0 are don't-care, except after reset (0).
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- SEGS=1 degenerates to a single registered add/sub with latency 1.
- The final segment's width is WIDTH-(SEGS-1)*SW. SEGS must satisfy (SEGS-1)*SW < WIDTH; other values are rejected with an elaboration-time error.
- No combinational path from in_valid/opa/opb to any output. in_ready depends combinationally on out_ready only.

Test Plan (WIDTH=27, SEGS=3, SW=9; out_ready=1 unless stated):
- add, opa=0x7FFFFFF, opb=0x0000001 -> after 3 cycles sum=0x0000000, co=1, ovf=0, zero=1.
- add, opa=0x00001FF, opb=0x0000001 (carry crosses segment 0->1) -> sum=0x0000200, co=0, zero=0.
- add, opa=0x0003FFFF, opb=0x1 (carry crosses segments 0->1->2) -> sum=0x0040000.
- add, opa=0x3FFFFFF, opb=0x0000001 -> sum=0x4000000, ovf=1, co=0.
- sub, opa=5, opb=7 -> sum=0x7FFFFFE, co=1 (borrow), ovf=0.
- sub, opa=7, opb=5 -> sum=0x0000002, co=0.
- Backpressure:
  - Stimulus: stream 6 back-to-back random ops; hold out_ready=0 for 4 cycles once out_valid rises.
  - Required: in_ready=0 and outputs stable during the hold; all 6 results later emerge in order and match the {co,sum}=add?opa+opb:opa-opb reference model; no loss or duplication.
- Reset mid-flight:
  - Stimulus: accept 2 ops, assert rst_n=0 for 1 cycle at the edge before the first result.
  - Required: out_valid=0 and sum=co=ovf=zero=0 next cycle; neither result is ever emitted; the next accepted op returns after 3 cycles.
